// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with valid/ready handshakes; shifts run on an iterative
// one-bit-per-cycle shifter, all other ops complete in a single cycle.
module alu_iter_exec #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   input  logic                  i_Valid,
   output logic                  o_Ready,
   input  logic [3:0]            i_ALUControlLines,
   input  logic [DATA_WIDTH-1:0] i_OperandA,
   input  logic [DATA_WIDTH-1:0] i_OperandB,
   output logic                  o_Valid,
   input  logic                  i_Ready,
   output logic [DATA_WIDTH-1:0] o_Result,
   output logic                  o_Zero,
   output logic                  o_Busy
);

   // ALU control encodings shared with the ALU control decoder
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_SLL   = 4'b0010;
   localparam logic [3:0] ALU_SLT   = 4'b0011;
   localparam logic [3:0] ALU_SLTU  = 4'b0100;
   localparam logic [3:0] ALU_XOR   = 4'b0101;
   localparam logic [3:0] ALU_SRL   = 4'b0110;
   localparam logic [3:0] ALU_SRA   = 4'b0111;
   localparam logic [3:0] ALU_OR    = 4'b1000;
   localparam logic [3:0] ALU_AND   = 4'b1001;
   localparam logic [3:0] ALU_LUI   = 4'b1010;
   localparam logic [3:0] ALU_AUIPC = 4'b1011;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state;
   state_t                 next_state;
   logic [DATA_WIDTH-1:0]  shift_reg;
   logic [DATA_WIDTH-1:0]  shift_next;
   logic [SHAMT_WIDTH-1:0] count;
   logic [3:0]             shift_op;
   logic [DATA_WIDTH-1:0]  single_res;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic                   accept;
   logic                   is_shift;
   logic                   start_shift;

   assign o_Ready     = (state == IDLE);
   assign o_Busy      = (state != IDLE);
   assign o_Valid     = (state == DONE);
   assign accept      = i_Valid && o_Ready;
   assign shamt       = i_OperandB[SHAMT_WIDTH-1:0];
   assign is_shift    = (i_ALUControlLines == ALU_SLL) || (i_ALUControlLines == ALU_SRL) ||
                        (i_ALUControlLines == ALU_SRA);
   assign start_shift = is_shift && (shamt != '0);

   // Unknown or unlisted codes fall to the default arm, so X never reaches the result
   always_comb begin
      single_res = '0;
      case (i_ALUControlLines)
         ALU_ADD:   single_res = i_OperandA + i_OperandB;
         ALU_SUB:   single_res = i_OperandA - i_OperandB;
         ALU_SLT:   single_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_OperandA) < $signed(i_OperandB))};
         ALU_SLTU:  single_res = {{(DATA_WIDTH-1){1'b0}}, (i_OperandA < i_OperandB)};
         ALU_XOR:   single_res = i_OperandA ^ i_OperandB;
         ALU_OR:    single_res = i_OperandA | i_OperandB;
         ALU_AND:   single_res = i_OperandA & i_OperandB;
         ALU_LUI:   single_res = i_OperandB;
         ALU_AUIPC: single_res = i_OperandA + i_OperandB;
         ALU_SLL, ALU_SRL, ALU_SRA: single_res = i_OperandA;
         default:   single_res = '0;
      endcase
   end

   always_comb begin
      shift_next = shift_reg;
      case (shift_op)
         ALU_SLL: shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
         ALU_SRL: shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
         ALU_SRA: shift_next = {shift_reg[DATA_WIDTH-1], shift_reg[DATA_WIDTH-1:1]};
         default: shift_next = shift_reg;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = start_shift ? SHIFT : DONE;
         SHIFT:   if (count == 1) next_state = DONE;
         DONE:    if (i_Ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Result and zero flag only change when an op finishes, so DONE holds them stable
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         shift_reg <= '0;
         count     <= '0;
         shift_op  <= ALU_ADD;
         o_Result  <= '0;
         o_Zero    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (start_shift) begin
                     shift_reg <= i_OperandA;
                     count     <= shamt;
                     shift_op  <= i_ALUControlLines;
                  end else begin
                     o_Result <= single_res;
                     o_Zero   <= (single_res == '0);
                  end
               end
            end
            SHIFT: begin
               shift_reg <= shift_next;
               count     <= count - 1'b1;
               if (count == 1) begin
                  o_Result <= shift_next;
                  o_Zero   <= (shift_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed vector table, randomized ops
// against an arithmetic reference model, plus reset and backpressure sequences.
module tb_alu_iter_exec;

   localparam int W = 32;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_SLL   = 4'b0010;
   localparam logic [3:0] OP_SLT   = 4'b0011;
   localparam logic [3:0] OP_SLTU  = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_SRL   = 4'b0110;
   localparam logic [3:0] OP_SRA   = 4'b0111;
   localparam logic [3:0] OP_OR    = 4'b1000;
   localparam logic [3:0] OP_AND   = 4'b1001;
   localparam logic [3:0] OP_LUI   = 4'b1010;
   localparam logic [3:0] OP_AUIPC = 4'b1011;
   localparam logic [3:0] OP_BAD   = 4'b1111;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         out_ready;
   logic [3:0]   ctrl;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         out_valid;
   logic         in_ready;
   logic [W-1:0] result;
   logic         zero;
   logic         busy;

   int checkCount = 0;
   int failCount  = 0;

   typedef struct {
      string        name;
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] expRes;
      int           expLat;
   } vec_t;

   vec_t vecs[$];

   alu_iter_exec #(.DATA_WIDTH(W), .SHAMT_WIDTH(5)) dut (
      .i_Clk            (clk),
      .i_Rst_n          (rst_n),
      .i_Valid          (in_valid),
      .o_Ready          (out_ready),
      .i_ALUControlLines(ctrl),
      .i_OperandA       (op_a),
      .i_OperandB       (op_b),
      .o_Valid          (out_valid),
      .i_Ready          (in_ready),
      .o_Result         (result),
      .o_Zero           (zero),
      .o_Busy           (busy)
   );

   always #5 clk = ~clk;

   // Reference model: plain arithmetic straight from the op definitions
   function automatic logic [W-1:0] refResult(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         OP_ADD, OP_AUIPC: return a + b;
         OP_SUB:           return a - b;
         OP_SLT:           return ($signed(a) < $signed(b)) ? 1 : 0;
         OP_SLTU:          return (a < b) ? 1 : 0;
         OP_XOR:           return a ^ b;
         OP_OR:            return a | b;
         OP_AND:           return a & b;
         OP_LUI:           return b;
         OP_SLL:           return a << sh;
         OP_SRL:           return a >> sh;
         OP_SRA:           return W'($signed(a) >>> sh);
         default:          return '0;
      endcase
   endfunction

   // Extra edges after acceptance before o_Valid is seen
   function automatic int refLatency(logic [3:0] op, logic [W-1:0] b);
      if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && b[4:0] != 0) return int'(b[4:0]);
      return 0;
   endfunction

   task automatic checkOutput(string name, logic [W-1:0] actual, logic [W-1:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Issues one op, scrambles the inputs after acceptance, then waits for o_Valid
   task automatic applyStimulus(string name, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                logic [W-1:0] expRes, int expLat);
      int edges;
      @(negedge clk);
      in_valid = 1'b1;
      ctrl     = op;
      op_a     = a;
      op_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ctrl     = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      edges    = 0;
      while (!out_valid && edges < 64) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checkOutput({name, " latency"}, W'(edges), W'(expLat));
      checkOutput({name, " result"}, result, expRes);
      checkOutput({name, " zero"}, W'(zero), W'(expRes == '0));
      if (in_ready) begin
         @(posedge clk);
         #1;
         checkOutput({name, " valid drop"}, W'(out_valid), 0);
         checkOutput({name, " ready back"}, W'(out_ready), 1);
      end
   endtask

   initial begin
      logic [3:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_ready = 1'b1;
      ctrl     = '0;
      op_a     = '0;
      op_b     = '0;

      vecs.push_back('{"add 5+7",      OP_ADD,   32'd5,        32'd7,        32'd12,       0});
      vecs.push_back('{"sub 9-9",      OP_SUB,   32'd9,        32'd9,        32'd0,        0});
      vecs.push_back('{"add wrap",     OP_ADD,   32'hFFFFFFFF, 32'd1,        32'd0,        0});
      vecs.push_back('{"sra by 4",     OP_SRA,   32'h80000000, 32'd4,        32'hF8000000, 4});
      vecs.push_back('{"srl by 4",     OP_SRL,   32'h80000000, 32'd4,        32'h08000000, 4});
      vecs.push_back('{"sll by 31",    OP_SLL,   32'd1,        32'd31,       32'h80000000, 31});
      vecs.push_back('{"sll shamt 0",  OP_SLL,   32'h00001234, 32'h00000020, 32'h00001234, 0});
      vecs.push_back('{"srl upper b",  OP_SRL,   32'hF0000000, 32'hFFFFFF25, 32'h07800000, 5});
      vecs.push_back('{"slt neg",      OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        0});
      vecs.push_back('{"sltu neg",     OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        0});
      vecs.push_back('{"lui",          OP_LUI,   32'hDEADBEEF, 32'h12345000, 32'h12345000, 0});
      vecs.push_back('{"auipc",        OP_AUIPC, 32'h00000100, 32'h00002000, 32'h00002100, 0});
      vecs.push_back('{"xor",          OP_XOR,   32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 0});
      vecs.push_back('{"or",           OP_OR,    32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0});
      vecs.push_back('{"and",          OP_AND,   32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0});
      vecs.push_back('{"sra pos",      OP_SRA,   32'h40000000, 32'd2,        32'h10000000, 2});
      vecs.push_back('{"undefined op", OP_BAD,   32'd5,        32'd5,        32'd0,        0});

      #12;
      checkOutput("reset valid", W'(out_valid), 0);
      checkOutput("reset result", result, 0);
      checkOutput("reset zero", W'(zero), 1);
      checkOutput("reset busy", W'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("reset ready", W'(out_ready), 1);

      foreach (vecs[i])
         applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expRes, vecs[i].expLat);

      // Reset in the middle of a long arithmetic shift discards the op
      applyStimulus("pre-reset add", OP_ADD, 32'd5, 32'd7, 32'd12, 0);
      @(negedge clk);
      in_valid = 1'b1;
      ctrl     = OP_SRA;
      op_a     = 32'h80000000;
      op_b     = 32'd20;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("mid-shift busy", W'(busy), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid-reset valid", W'(out_valid), 0);
      checkOutput("mid-reset busy", W'(busy), 0);
      checkOutput("mid-reset result", result, 0);
      checkOutput("mid-reset zero", W'(zero), 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("post-reset ready", W'(out_ready), 1);
      applyStimulus("post-reset sub", OP_SUB, 32'd20, 32'd3, 32'd17, 0);

      // Backpressure: result held in DONE, new requests ignored
      in_ready = 1'b0;
      applyStimulus("bp add", OP_ADD, 32'd3, 32'd4, 32'd7, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         ctrl     = OP_ADD;
         op_a     = 32'd100 + 32'(k);
         op_b     = 32'd1;
         @(posedge clk);
         #1;
         checkOutput("bp result held", result, 32'd7);
         checkOutput("bp ready low", W'(out_ready), 0);
         checkOutput("bp valid held", W'(out_valid), 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp valid drop", W'(out_valid), 0);
      checkOutput("bp ready rise", W'(out_ready), 1);
      checkOutput("bp no extra op", W'(busy), 0);
      checkOutput("bp result after", result, 32'd7);

      // Randomized ops against the reference model
      for (int n = 0; n < 60; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         if ($urandom_range(0, 4) == 0) ra = '0;
         applyStimulus($sformatf("rand%0d op%0d", n, rop), rop, ra, rb,
                       refResult(rop, ra, rb), refLatency(rop, rb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU datapath. Directly consumes the 4-bit ALU control code produced by the ALU control decoder.
- Single-op valid/ready handshake on both sides. Most ops complete in one cycle.
- SLL/SRL/SRA use an area-saving iterative 1-bit-per-cycle shifter, so latency depends on the shift amount.
- Result and zero flag are registered and held until the downstream stage (branch/writeback) accepts them.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from operand B; must equal log2(DATA_WIDTH).

Ports:
- i_Clk  input  1  clock, rising-edge.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_Valid  input  1  upstream op valid.
- o_Ready  output  1  block can accept an op.
- i_ALUControlLines  input  4  op code, using the ALU_* encodings of ALU_CONTROL.vh.
- i_OperandA  input  DATA_WIDTH  rs1 value, or PC for AUIPC.
- i_OperandB  input  DATA_WIDTH  rs2 value or immediate.
- o_Valid  output  1  result valid.
- i_Ready  input  1  downstream accepts result.
- o_Result  output  DATA_WIDTH  registered result.
- o_Zero  output  1  registered flag: o_Result == 0.
- o_Busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, i_Rst_n=0), effective immediately and regardless of state, including mid-SHIFT (the in-flight op is discarded):
  - state=IDLE
  - o_Valid=0, o_Result=0, o_Zero=1
  - shift register=0, count=0
- o_Ready = (state==IDLE).
- Acceptance occurs on a rising edge with i_Valid && o_Ready. The op code and operands are captured then; later input changes are ignored.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on acceptance:
  - Op is SLL/SRL/SRA and B[SHAMT_WIDTH-1:0] != 0: load shift register with A, count=shamt, latch the shift kind, go to SHIFT.
  - Otherwise: compute the single-cycle result into o_Result/o_Zero, go to DONE.
  - SLL/SRL/SRA with shamt 0: result = A.
- SHIFT, each cycle:
  - Shift by 1. SLL: left, zero fill. SRL: right, zero fill. SRA: right, fill with bit DATA_WIDTH-1.
  - Decrement count.
  - On the cycle where count==1, write the shifted value to o_Result/o_Zero and go to DONE.
- DONE:
  - o_Valid=1; o_Result and o_Zero held stable.
  - On i_Ready=1 at an edge: go to IDLE, o_Valid=0.
  - No acceptance of new ops while in DONE.
- Latency, acceptance edge to o_Valid: non-shift or shamt 0 → 1 cycle; shift by k (k>=1) → k+1 cycles.
- Throughput: at most one op per 2 cycles.
- Single-cycle ops, all arithmetic modulo 2^DATA_WIDTH, carries discarded:
  - ADD: A+B
  - SUB: A-B
  - SLT: signed A<B → 1, else 0, zero-extended
  - SLTU: unsigned compare, otherwise as SLT
  - XOR / OR / AND: bitwise
  - LUI: B
  - AUIPC: A+B
- Only B[SHAMT_WIDTH-1:0] is used as the shift amount; the upper bits of B are ignored.
- Any unlisted or X control code: result=0, o_Zero=1, completes as a 1-cycle op. The block never propagates X to o_Result.
- o_Zero always tracks the registered o_Result. Branch logic uses SUB plus o_Zero.
- i_Ready while o_Valid=0: no effect.

Test Plan:
- Reset mid-op: accept SRA with shamt 20, drop i_Rst_n after 3 cycles → immediately o_Valid=0, o_Busy=0, o_Result=0, o_Zero=1. After release, o_Ready=1 and the next op completes normally.
- Single-cycle ops, i_Ready held high:
  - ADD 5+7 → o_Valid 1 cycle after acceptance, o_Result=12, o_Zero=0.
  - SUB 9-9 → 0, o_Zero=1.
  - ADD 0xFFFFFFFF+1 → 0, o_Zero=1.
- Iterative shifts with A=0x80000000, B=4 (i_Ready high):
  - SRA → o_Valid on the 5th edge after acceptance, o_Result=0xF8000000.
  - SRL → 0x08000000.
  - SLL with A=1, B=31 → 0x80000000 after 32 cycles.
- Shift edge cases:
  - SLL with B=0x20 (shamt 0) → o_Result=A after 1 cycle, never enters SHIFT.
  - SRL with B=0xFFFFFF25 → shift by 5.
- Backpressure: hold i_Ready=0 for 4 cycles in DONE while pulsing i_Valid → o_Result stable, o_Ready=0, no op accepted. On raising i_Ready: o_Valid drops next edge, o_Ready rises.
- Compare and upper-immediate ops:
  - SLT A=0xFFFFFFFF, B=1 → 1; SLTU with same operands → 0.
  - LUI B=0x12345000 → 0x12345000.
  - AUIPC A=0x100, B=0x2000 → 0x2100.
  - Undefined control code → 0 with o_Zero=1.
